// File: rtl/ram_port_arbiter_pkg.sv
// ram_arb_pkg: response owner encoding and default parameters for the RAM port arbiter
package ram_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;
  localparam int DefDataW = 32;
  localparam int DefAddrSize = 32;
  localparam int DefMaxWait = 4;
endpackage

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM port between ifetch refill and data load/store with bounded ifetch starvation
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int dataW = DefDataW,
  parameter int RAMAddrSize = DefAddrSize,
  parameter int MaxWait = DefMaxWait
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   if_req,
  input  logic [RAMAddrSize-1:0] if_addr,
  output logic                   if_gnt,
  output logic                   if_rvalid,
  output logic [dataW-1:0]       if_rdata,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [RAMAddrSize-1:0] d_addr,
  input  logic [dataW-1:0]       d_wdata,
  output logic                   d_gnt,
  output logic                   d_rvalid,
  output logic [dataW-1:0]       d_rdata,
  output logic [RAMAddrSize-1:0] ram_addr,
  output logic                   ram_we,
  output logic                   ram_re,
  output logic [dataW-1:0]       ram_wdata,
  input  logic [dataW-1:0]       ram_rdata
);
  // a zero-width counter is illegal, so MaxWait 0 keeps one bit that never leaves zero
  localparam int CntW = MaxWait > 0 ? $clog2(MaxWait + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MaxWait);
  logic [CntW-1:0] starveCnt;
  owner_t owner;
  // data wins conflicts until ifetch has lost MaxWait times in a row; drive the RAM from the winner
  always_comb begin
    if_gnt = if_req & (~d_req | starveCnt == CntMax);
    d_gnt = d_req & ~if_gnt;
    ram_re = if_gnt | (d_gnt & ~d_we);
    ram_we = d_gnt & d_we;
    ram_addr = if_gnt ? if_addr : d_gnt ? d_addr : '0;
    ram_wdata = d_gnt ? d_wdata : '0;
    if_rvalid = owner == OWN_IF;
    d_rvalid = owner == OWN_D;
    if_rdata = ram_rdata;
    d_rdata = ram_rdata;
  end
  // count consecutive lost conflicts while ifetch is waiting, saturating at MaxWait
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) starveCnt <= '0;
    else if (!if_req || if_gnt) starveCnt <= '0;
    else if (starveCnt != CntMax) starveCnt <= starveCnt + 1'b1;
  end
  // remember who issued this cycle's read so the next cycle's response goes back to them
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) owner <= OWN_NONE;
    else owner <= if_gnt ? OWN_IF : (d_gnt && !d_we) ? OWN_D : OWN_NONE;
  end
endmodule
